// File: rtl/fir_tap_loader.sv
// Tap-coefficient loader: software-written tap RAM streamed to a FIR core over
// a valid/ready port, with sticky done / timeout / write-collision status.
module fir_tap_loader #(
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_DONE_TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [G_NUM_TAPS_LOG2-1:0] wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     wr_data,
  input  logic                       wr_en,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       wr_collision,
  output logic [G_TAP_WIDTH-1:0]     tap_dout,
  output logic                       tap_dout_valid,
  input  logic                       tap_dout_ready,
  output logic                       tap_dout_last,
  input  logic                       tap_sink_done
);

  localparam int                         N        = 1 << G_NUM_TAPS_LOG2;
  localparam logic [G_NUM_TAPS_LOG2-1:0] LAST_IDX = {G_NUM_TAPS_LOG2{1'b1}};
  localparam logic [7:0]                 TO_LAST  = 8'(G_DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, WAIT_DONE} state_t;

  state_t                     state;
  logic [G_NUM_TAPS_LOG2-1:0] idx;
  logic [G_NUM_TAPS_LOG2-1:0] idx_nxt;
  logic [G_NUM_TAPS_LOG2-1:0] rd_addr;
  logic [7:0]                 timer;
  logic                       fire;
  logic [G_TAP_WIDTH-1:0]     ram [N];

  assign fire    = tap_dout_valid & tap_dout_ready;
  assign idx_nxt = idx + 1'b1;
  // Re-reading the current index while stalled keeps tap_dout stable; the RAM
  // cannot change underneath because writes are dropped outside IDLE.
  assign rd_addr = (state == STREAM && fire) ? idx_nxt : idx;

  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE)
      ram[wr_addr] <= wr_data;
    tap_dout <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state          <= IDLE;
      idx            <= '0;
      timer          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      wr_collision   <= 1'b0;
      tap_dout_valid <= 1'b0;
      tap_dout_last  <= 1'b0;
    end else begin
      if (wr_en && state != IDLE)
        wr_collision <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= FETCH;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            wr_collision <= 1'b0;
            idx          <= '0;
            timer        <= '0;
          end
        end
        FETCH: begin
          state          <= STREAM;
          tap_dout_valid <= 1'b1;
          tap_dout_last  <= (idx == LAST_IDX);
        end
        STREAM: begin
          if (fire) begin
            if (idx == LAST_IDX) begin
              state          <= WAIT_DONE;
              tap_dout_valid <= 1'b0;
              tap_dout_last  <= 1'b0;
              timer          <= '0;
            end else begin
              idx           <= idx_nxt;
              tap_dout_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        WAIT_DONE: begin
          if (tap_sink_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (timer == TO_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Scoreboard bench for fir_tap_loader: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted beat and checks stall hold.
module tb_fir_tap_loader;
  localparam int N = 16;
  localparam int T = 10;

  logic        clk = 1'b0;
  logic        reset, enable, wr_en, start, tap_dout_ready, tap_sink_done;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy, done, error, wr_collision, tap_dout_valid, tap_dout_last;
  logic [15:0] tap_dout;

  int vecs = 0;
  int errs = 0;
  logic [15:0] exp_q[$];
  bit          explast_q[$];
  logic [15:0] model [N];

  always #5 clk = ~clk;

  fir_tap_loader #(.G_NUM_TAPS_LOG2(4), .G_TAP_WIDTH(16), .G_DONE_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .start(start),
    .busy(busy), .done(done), .error(error), .wr_collision(wr_collision),
    .tap_dout(tap_dout), .tap_dout_valid(tap_dout_valid),
    .tap_dout_ready(tap_dout_ready), .tap_dout_last(tap_dout_last),
    .tap_sink_done(tap_sink_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one pop per accepted beat; a stalled beat must hold next cycle.
  logic [15:0] prev_d;
  logic        prev_l;
  bit          have_prev = 0;
  always @(negedge clk) begin
    if (tap_dout_valid) begin
      if (have_prev) begin
        chk("stall_data", 32'(tap_dout), 32'(prev_d));
        chk("stall_last", 32'(tap_dout_last), 32'(prev_l));
      end
      if (tap_dout_ready) begin
        have_prev = 0;
        if (exp_q.size() == 0) chk("extra_beat", 32'(tap_dout), 32'hFFFF_FFFF);
        else begin
          chk("beat_data", 32'(tap_dout), 32'(exp_q.pop_front()));
          chk("beat_last", 32'(tap_dout_last), 32'(explast_q.pop_front()));
        end
      end else begin
        have_prev = 1;
        prev_d    = tap_dout;
        prev_l    = tap_dout_last;
      end
    end else begin
      have_prev = 0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_load(input bit rnd, input bit give_done, input bit collide, input bit wr0);
    int  edges;
    bit  got;
    if (wr0) begin
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; model[0] = 16'h1234;
    end
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(model[i]);
      explast_q.push_back(i == N - 1);
    end
    start = 1'b1;
    step();
    start = 1'b0; wr_en = 1'b0;
    chk("busy_fetch", 32'(busy), 32'd1);
    chk("flags_clr", 32'({done, error, wr_collision}), 32'd0);
    got = 0; edges = 0;
    for (int c = 0; c < 500 && !got; c++) begin
      tap_dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (collide && c == 3) begin
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
      end else wr_en = 1'b0;
      @(negedge clk);
      got = tap_dout_valid && tap_dout_ready && tap_dout_last;
      step();
      edges++;
    end
    wr_en = 1'b0; tap_dout_ready = 1'b0;
    if (!got) begin
      chk("last_seen", 32'd0, 32'd1);
      return;
    end
    if (!rnd) chk("last_edge", 32'(edges), 32'(N + 1));
    chk("wait_state", 32'({busy, tap_dout_valid, done}), 32'b100);
    if (give_done) begin
      tap_sink_done = 1'b1;
      step();
      tap_sink_done = 1'b0;
      chk("done_set", 32'({done, error, busy}), 32'b100);
    end else begin
      for (int k = 1; k <= T; k++) begin
        step();
        if (k < T) chk("to_pending", 32'({error, busy}), 32'b01);
        else       chk("to_error", 32'({error, done, busy}), 32'b100);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1; wr_en = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; tap_dout_ready = 1'b0; tap_sink_done = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({done, error, wr_collision}), 32'd0);
    chk("rst_valid", 32'({tap_dout_valid, tap_dout_last}), 32'd0);

    for (int i = 0; i < N; i++) wr(4'(i), 16'(i * 16'h0101));

    run_load(0, 1, 0, 0);                  // basic
    run_load(1, 1, 0, 0);                  // backpressure
    run_load(0, 0, 0, 0);                  // timeout
    run_load(0, 1, 1, 0);                  // collision during STREAM
    chk("collision", 32'(wr_collision), 32'd1);
    run_load(0, 1, 0, 0);                  // RAM[3] must still be 0x0303

    // Abort: five beats, then drop enable mid-stream.
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(model[i]);
      explast_q.push_back(i == N - 1);
    end
    start = 1'b1; tap_dout_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    tap_dout_ready = 1'b0; enable = 1'b0;
    step();
    chk("abort_left", 32'(exp_q.size()), 32'(N - 5));
    chk("abort_state", 32'({busy, done, error, wr_collision, tap_dout_valid, tap_dout_last}), 32'd0);
    exp_q.delete();
    explast_q.delete();
    enable = 1'b1;
    step();
    run_load(0, 1, 0, 0);                  // full restart from tap 0

    run_load(0, 1, 0, 1);                  // write+start same cycle

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
